// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer for the 5-stage MIPS core: drives the ID stall mux,
// PC / IF-ID write enables and the IF flush, tracks multi-cycle EX occupancy and
// keeps a saturating count of stall cycles.
module hazard_stall_ctrl #(
    parameter int unsigned MULTI_LAT = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_MultiCycle,
    input  logic             ID_BranchTaken,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    output logic             Stall,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_Flush,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic [0:0] {StIdle, StMulti} state_e;

    // Frozen cycles after the issue cycle; a latency of 1 never leaves idle.
    localparam logic [4:0] OccLoad   = 5'(MULTI_LAT - 1);
    localparam bit         MultiUsed = (MULTI_LAT > 1);

    state_e     state_q, state_d;
    logic [4:0] occ_q, occ_d;
    logic       lu;
    logic       stall_c, pcw_c, ifw_c, flush_c, busy_c;

    // Register 0 is hard-wired to zero, so a load into it is never a hazard.
    assign lu = EX_MemRead && (EX_Rt != 5'd0) &&
                ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    // Next-state and same-cycle control outputs.
    always_comb begin
        state_d = state_q;
        occ_d   = occ_q;
        stall_c = 1'b0;
        pcw_c   = 1'b1;
        ifw_c   = 1'b1;
        flush_c = 1'b0;
        busy_c  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (lu) begin
                    // ID is held, so branch / multi-cycle requests are re-seen next cycle.
                    stall_c = 1'b1;
                    pcw_c   = 1'b0;
                    ifw_c   = 1'b0;
                end else begin
                    flush_c = ID_BranchTaken;
                    if (ID_MultiCycle && MultiUsed) begin
                        state_d = StMulti;
                        occ_d   = OccLoad;
                    end
                end
            end
            StMulti: begin
                stall_c = 1'b1;
                pcw_c   = 1'b0;
                ifw_c   = 1'b0;
                busy_c  = 1'b1;
                if (occ_q <= 5'd1) begin
                    state_d = StIdle;
                    occ_d   = 5'd0;
                end else begin
                    occ_d = occ_q - 5'd1;
                end
            end
            default: begin
                state_d = StIdle;
                occ_d   = 5'd0;
            end
        endcase
        // Reset forces a safe frozen pipeline regardless of state.
        if (!rst_n) begin
            stall_c = 1'b1;
            pcw_c   = 1'b0;
            ifw_c   = 1'b0;
            flush_c = 1'b0;
            busy_c  = 1'b0;
        end
    end

    assign Stall       = stall_c;
    assign PCWrite     = pcw_c;
    assign IF_ID_Write = ifw_c;
    assign IF_Flush    = flush_c;
    assign Busy        = busy_c;

    // FSM state and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            occ_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
        end
    end

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
        end else if (stall_c && (StallCount != {CNT_W{1'b1}})) begin
            StallCount <= StallCount + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a default instance (MULTI_LAT=4,
// CNT_W=16) and a CNT_W=2 instance sharing the same stimulus.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ID_Rs = '0, ID_Rt = '0, EX_Rt = '0;
    logic        ID_UsesRt = 1'b0, ID_MultiCycle = 1'b0, ID_BranchTaken = 1'b0;
    logic        EX_MemRead = 1'b0;
    logic        Stall, PCWrite, IF_ID_Write, IF_Flush, Busy;
    logic [15:0] StallCount;
    logic        Stall2, PCWrite2, IF_ID_Write2, IF_Flush2, Busy2;
    logic [1:0]  StallCount2;

    int          checks = 0;
    int          fails  = 0;
    int          sc     = 0;   // model of StallCount (CNT_W=16)
    int          sc2    = 0;   // model of StallCount2 (CNT_W=2)
    logic [4:0]  exp_q[$];     // expected {Stall,PCWrite,IF_ID_Write,IF_Flush,Busy}
    logic [4:0]  got, outs;

    localparam logic [4:0] EIssue = 5'b01100;
    localparam logic [4:0] EStall = 5'b10000;
    localparam logic [4:0] EBusy  = 5'b10001;
    localparam logic [4:0] EFlush = 5'b01110;

    hazard_stall_ctrl #(.MULTI_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_MultiCycle(ID_MultiCycle), .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .Stall(Stall), .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write), .IF_Flush(IF_Flush), .Busy(Busy), .StallCount(StallCount)
    );

    hazard_stall_ctrl #(.MULTI_LAT(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_MultiCycle(ID_MultiCycle), .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .Stall(Stall2), .PCWrite(PCWrite2),
        .IF_ID_Write(IF_ID_Write2), .IF_Flush(IF_Flush2), .Busy(Busy2),
        .StallCount(StallCount2)
    );

    always #5 clk = ~clk;

    assign outs = {Stall, PCWrite, IF_ID_Write, IF_Flush, Busy};

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                          input logic multi, input logic br, input logic memrd,
                          input logic [4:0] ex_rt);
        ID_Rs = rs; ID_Rt = rt; ID_UsesRt = uses_rt; ID_MultiCycle = multi;
        ID_BranchTaken = br; EX_MemRead = memrd; EX_Rt = ex_rt;
    endtask

    // Advance one clock edge and update the counter models from the expected stall.
    task automatic tick(input logic exp_stall);
        @(posedge clk);
        if (rst_n && exp_stall) begin
            if (sc < 65535) sc++;
            if (sc2 < 3) sc2++;
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(EStall);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (outs !== got || StallCount !== 16'(sc)) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: outs=%b cnt=%0d expected outs=%b cnt=%0d",
                         i, outs, StallCount, got, sc);
            end
            tick(1'b1);
        end
        rst_n = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        exp_q.push_back(EIssue);
        @(negedge clk);
        got = exp_q.pop_front();
        checks++;
        if (outs !== got || StallCount !== 16'(sc) || sc != 0) begin
            fails++;
            $display("FAIL reset_release: outs=%b cnt=%0d expected outs=%b cnt=0",
                     outs, StallCount, got);
        end
        tick(1'b0);
    endtask

    task automatic test_load_use_rs();
        logic [4:0] pat[2];
        pat[0] = EStall;
        pat[1] = EIssue;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
            else        set_in(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
            exp_q.push_back(pat[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (outs !== got || StallCount !== 16'(sc)) begin
                fails++;
                $display("FAIL load_use_rs cyc%0d: outs=%b cnt=%0d expected outs=%b cnt=%0d",
                         i, outs, StallCount, got, sc);
            end
            tick(got[4]);
        end
        checks++;
        if (StallCount !== 16'd1) begin
            fails++;
            $display("FAIL load_use_rs_count: cnt=%0d expected 1", StallCount);
        end
    endtask

    task automatic test_no_hazard();
        for (int i = 0; i < 4; i++) begin
            unique case (i)
                0: begin set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0); exp_q.push_back(EIssue); end
                1: begin set_in(5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9); exp_q.push_back(EIssue); end
                2: begin set_in(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9); exp_q.push_back(EStall); end
                default: begin set_in(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4); exp_q.push_back(EIssue); end
            endcase
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (outs !== got || StallCount !== 16'(sc)) begin
                fails++;
                $display("FAIL no_hazard case%0d: outs=%b cnt=%0d expected outs=%b cnt=%0d",
                         i, outs, StallCount, got, sc);
            end
            tick(got[4]);
        end
    endtask

    // Issue, three frozen cycles with noisy inputs, then a back-to-back issue.
    task automatic test_multi_back_to_back();
        int base;
        base = sc;
        for (int i = 0; i < 9; i++) begin
            if (i == 0 || i == 4)
                set_in(5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
            else if (i == 8)
                set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
            else
                set_in(5'd7, 5'd7, 1'b1, 1'(i[0]), 1'b1, 1'b1, 5'd7);
            if (i == 0 || i == 4 || i == 8) exp_q.push_back(EIssue);
            else exp_q.push_back(EBusy);
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (outs !== got || StallCount !== 16'(sc)) begin
                fails++;
                $display("FAIL multi cyc%0d: outs=%b cnt=%0d expected outs=%b cnt=%0d",
                         i, outs, StallCount, got, sc);
            end
            tick(got[4]);
        end
        checks++;
        if (StallCount !== 16'(base + 6)) begin
            fails++;
            $display("FAIL multi_count: cnt=%0d expected %0d", StallCount, base + 6);
        end
    endtask

    task automatic test_branch_with_lu();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
                exp_q.push_back(EStall);
            end else begin
                set_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
                exp_q.push_back(EFlush);
            end
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if (outs !== got) begin
                fails++;
                $display("FAIL branch_lu cyc%0d: outs=%b expected outs=%b", i, outs, got);
            end
            tick(got[4]);
        end
    endtask

    task automatic test_saturation();
        // Fresh start so the narrow counter begins at zero.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sc = 0;
        sc2 = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                set_in(5'd11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11);
                exp_q.push_back(EStall);
            end else begin
                set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
                exp_q.push_back(EIssue);
            end
            @(negedge clk);
            got = exp_q.pop_front();
            checks++;
            if ({Stall2, PCWrite2, IF_ID_Write2, IF_Flush2, Busy2} !== got ||
                StallCount2 !== 2'(sc2)) begin
                fails++;
                $display("FAIL saturate cyc%0d: outs=%b cnt=%0d expected outs=%b cnt=%0d", i,
                         {Stall2, PCWrite2, IF_ID_Write2, IF_Flush2, Busy2}, StallCount2, got, sc2);
            end
            tick(got[4]);
        end
        checks++;
        if (StallCount2 !== 2'd3 || StallCount !== 16'd5) begin
            fails++;
            $display("FAIL saturate_final: cnt2=%0d cnt=%0d expected cnt2=3 cnt=5",
                     StallCount2, StallCount);
        end
    endtask

    task automatic test_reset_mid_multi();
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        tick(1'b0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        tick(1'b1);
        exp_q.push_back(EBusy);
        #1;
        got = exp_q.pop_front();
        checks++;
        if (outs !== got) begin
            fails++;
            $display("FAIL mid_multi_busy: outs=%b expected outs=%b", outs, got);
        end
        // Assert reset between edges: outputs and counter must react without a clock.
        rst_n = 1'b0;
        exp_q.push_back(EStall);
        #1;
        got = exp_q.pop_front();
        checks++;
        if (outs !== got || StallCount !== 16'd0 || StallCount2 !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid_multi: outs=%b cnt=%0d cnt2=%0d expected outs=%b cnt=0",
                     outs, StallCount, StallCount2, got);
        end
        sc = 0;
        sc2 = 0;
        tick(1'b1);
        rst_n = 1'b1;
        exp_q.push_back(EIssue);
        @(negedge clk);
        got = exp_q.pop_front();
        checks++;
        if (outs !== got || StallCount !== 16'd0) begin
            fails++;
            $display("FAIL after_reset_idle: outs=%b cnt=%0d expected outs=%b cnt=0",
                     outs, StallCount, got);
        end
        tick(1'b0);
    endtask

    initial begin
        #1;
        test_reset();
        test_load_use_rs();
        test_no_hazard();
        test_multi_back_to_back();
        test_branch_with_lu();
        test_saturation();
        test_reset_mid_multi();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard time limit so a broken design cannot hang the run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
